// File: rtl/sseg_pkg.sv
// Shared glyph table, scan-sample layout and FSM state type for the seven-segment scan monitor.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba glyphs for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
  } scan_t;

  localparam scan_t SCAN_BLANK = '{an: 4'hF, sseg: 7'h7F, dp: 1'b1};

  // True when exactly one active-low anode is driven.
  function automatic logic one_low(input logic [3:0] an);
    logic [3:0] low;
    low = ~an;
    return (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
  endfunction

endpackage

// File: rtl/sseg_glyph_decoder.sv
// Combinational glyph -> hex lookup; exact gfedcba match only, anything else reads as invalid with hex 0.
// Zero latency, no flow control.
module sseg_glyph_decoder
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] hex
);

  always_comb begin
    valid = 1'b0;
    hex   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        valid = 1'b1;
        hex   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds 4-digit frames from scanned an/sseg/dp lines; capture 2 sync + SETTLE_CYCLES after an input edge,
// frame strobe one cycle after the final capture. Pure monitor: never stalls the observed driver.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  sseg_i,
  input  logic        dp_i,
  output logic [31:0] digit_pattern_o,
  output logic [15:0] hex_o,
  output logic [3:0]  hex_valid_o,
  output logic        frame_strobe_o,
  output logic        frame_valid_o,
  output logic        error_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  scan_t       sync1, s, prev;
  state_t      state, state_next;
  logic [SW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]  mask;
  logic [7:0]  shadow [4];
  logic [3:0]  dec_hex [4];
  logic [3:0]  dec_vld;
  logic [1:0]  idx;
  logic        is_blank, is_valid, is_illegal, prev_illegal, same;
  logic        capture, cnt_load, cnt_inc, frame_done, timeout;

  // Synchroniser resets to an idle bus so reset never looks like an illegal sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= SCAN_BLANK;
      s     <= SCAN_BLANK;
      prev  <= SCAN_BLANK;
    end else begin
      sync1 <= '{an: an_i, sseg: sseg_i, dp: dp_i};
      s     <= sync1;
      prev  <= s;
    end
  end

  assign is_blank     = &s.an;
  assign is_valid     = one_low(s.an);
  assign is_illegal   = !is_blank && !is_valid;
  assign prev_illegal = !(&prev.an) && !one_low(prev.an);
  assign same         = (s == prev);
  assign frame_done   = (mask == 4'hF);
  assign timeout      = (tcnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!s.an[i]) idx = 2'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_valid) state_next = SETTLE;
      SETTLE: begin
        if (!is_valid)                                    state_next = IDLE;
        else if (same && cnt == SW'(SETTLE_CYCLES - 1))  state_next = HELD;
      end
      HELD:    if (!same) state_next = is_valid ? SETTLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == SETTLE) && is_valid && same && (cnt == SW'(SETTLE_CYCLES - 1));
    cnt_load = is_valid && ((state == IDLE) || !same);
    cnt_inc  = (state == SETTLE) && is_valid && same;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      tcnt <= '0;
      mask <= 4'h0;
      for (int k = 0; k < 4; k++) shadow[k] <= {1'b0, SEG_BLANK};
    end else begin
      if (cnt_load)     cnt <= SW'(1);
      else if (cnt_inc) cnt <= cnt + SW'(1);

      if (capture)       tcnt <= '0;
      else if (!timeout) tcnt <= tcnt + TW'(1);

      // A capture on the completion edge seeds the next frame.
      mask <= ((frame_done || timeout) ? 4'h0 : mask) | (capture ? (4'b0001 << idx) : 4'h0);
      if (capture) shadow[idx] <= ~{s.dp, s.sseg};
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_dec
    sseg_glyph_decoder u_dec (
      .pattern (shadow[k][6:0]),
      .valid   (dec_vld[k]),
      .hex     (dec_hex[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_pattern_o <= '0;
      hex_o           <= '0;
      hex_valid_o     <= '0;
      frame_strobe_o  <= 1'b0;
      frame_valid_o   <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      frame_strobe_o <= frame_done;
      error_o        <= is_illegal && !prev_illegal;
      if (frame_done) begin
        for (int k = 0; k < 4; k++) begin
          digit_pattern_o[8*k +: 8] <= shadow[k];
          hex_o[4*k +: 4]           <= dec_hex[k];
        end
        hex_valid_o   <= dec_vld;
        frame_valid_o <= 1'b1;
      end else if (timeout) begin
        frame_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: frames, short dwell, illegal anodes, heartbeat glyph, timeout, mid-frame reset.
module tb_sseg_scan_decoder;
  import sseg_pkg::*;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] HB = 7'b1001111;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic [31:0] digit_pattern;
  logic [15:0] hex;
  logic [3:0]  hex_valid;
  logic        frame_strobe, frame_valid, error;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int errs = 0;
  int base_s, base_e;

  sseg_scan_decoder #(.SETTLE_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .an_i            (an),
    .sseg_i          (sseg),
    .dp_i            (dp),
    .digit_pattern_o (digit_pattern),
    .hex_o           (hex),
    .hex_valid_o     (hex_valid),
    .frame_strobe_o  (frame_strobe),
    .frame_valid_o   (frame_valid),
    .error_o         (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_strobe === 1'b1) strobes <= strobes + 1;
    if (error === 1'b1)        errs    <= errs + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [1:0] k, input logic [6:0] g, input logic d, input int n);
    an   = ~(4'b0001 << k);
    sseg = g;
    dp   = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an   = 4'hF;
    sseg = 7'h7F;
    dp   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] g0, g1, g2, g3, input logic d1);
    scan(2'd0, g0, 1'b1, 16);
    scan(2'd1, g1, d1, 16);
    scan(2'd2, g2, 1'b1, 16);
    scan(2'd3, g3, 1'b1, 16);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pattern"}, digit_pattern, 32'h0);
    check({tag, "_hex"}, {16'h0, hex}, 32'h0);
    check({tag, "_hexvalid"}, {28'h0, hex_valid}, 32'h0);
    check({tag, "_strobe"}, {31'h0, frame_strobe}, 32'h0);
    check({tag, "_fvalid"}, {31'h0, frame_valid}, 32'h0);
    check({tag, "_error"}, {31'h0, error}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(3);

    // Clean frame 0..3
    base_s = strobes; base_e = errs;
    frame(G0, G1, G2, G3, 1'b1);
    idle(4);
    check("frame1_strobes", strobes - base_s, 1);
    check("frame1_hex", {16'h0, hex}, 32'h3210);
    check("frame1_hexvalid", {28'h0, hex_valid}, 32'hF);
    check("frame1_byte0", {24'h0, digit_pattern[7:0]}, 32'h3F);
    check("frame1_pattern", digit_pattern, 32'h4F5B063F);
    check("frame1_fvalid", {31'h0, frame_valid}, 1);
    check("frame1_noerror", errs - base_e, 0);

    // Digit 2 dwells one sample short of settling
    base_s = strobes;
    scan(2'd0, G0, 1'b1, 16);
    scan(2'd1, G1, 1'b1, 16);
    scan(2'd2, G2, 1'b1, 7);
    scan(2'd3, G3, 1'b1, 16);
    scan(2'd0, G0, 1'b1, 16);
    idle(4);
    check("short_no_strobe", strobes - base_s, 0);
    check("short_mask", {28'h0, dut.mask}, 32'hB);
    scan(2'd2, G2, 1'b1, 16);
    idle(4);
    check("short_rescan_strobe", strobes - base_s, 1);
    check("short_rescan_hex", {16'h0, hex}, 32'h3210);

    // Illegal anode pattern straight out of a held digit
    scan(2'd0, G0, 1'b1, 16);
    base_e = errs;
    an = 4'b1100;
    repeat (5) @(negedge clk);
    check("illegal_state", {30'h0, dut.state}, 32'(IDLE));
    idle(4);
    check("illegal_one_error", errs - base_e, 1);
    check("illegal_no_capture", {28'h0, dut.mask}, 32'h1);

    // Heartbeat glyph on digit 1 with its decimal point lit
    base_s = strobes;
    frame(G0, HB, G2, G3, 1'b0);
    idle(4);
    check("hb_strobe", strobes - base_s, 1);
    check("hb_hexvalid", {28'h0, hex_valid}, 32'hD);
    check("hb_nibble1", {28'h0, hex[7:4]}, 32'h0);
    check("hb_byte1", {24'h0, digit_pattern[15:8]}, 32'hB0);
    check("hb_hex", {16'h0, hex}, 32'h3200);

    // Scanning stops: frame_valid must drop while outputs hold
    idle(50);
    check("timeout_still_valid", {31'h0, frame_valid}, 1);
    idle(60);
    check("timeout_dropped", {31'h0, frame_valid}, 0);
    check("timeout_hex_kept", {16'h0, hex}, 32'h3200);
    check("timeout_hexvalid_kept", {28'h0, hex_valid}, 32'hD);

    // Reset after three captures discards the partial frame
    scan(2'd0, G0, 1'b1, 16);
    scan(2'd1, G1, 1'b1, 16);
    scan(2'd2, G2, 1'b1, 16);
    check("partial_mask", {28'h0, dut.mask}, 32'h7);
    rst = 1'b1;
    idle(3);
    check_zero("midreset");
    rst = 1'b0;
    base_s = strobes;
    scan(2'd3, G3, 1'b1, 16);
    idle(4);
    check("postreset_no_strobe", strobes - base_s, 0);
    check("postreset_mask", {28'h0, dut.mask}, 32'h8);
    scan(2'd0, G0, 1'b1, 16);
    scan(2'd1, G1, 1'b1, 16);
    scan(2'd2, G2, 1'b1, 16);
    idle(4);
    check("postreset_strobe", strobes - base_s, 1);
    check("postreset_hex", {16'h0, hex}, 32'h3210);
    check("postreset_fvalid", {31'h0, frame_valid}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
